// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter: FSM states, grant codes and
// the width of the urgent-video run counter.
package ram_port_arbiter_pkg;

   localparam int RUN_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUS_ACCESS,
      VIDEO_ACCESS
   } state_t;

   typedef enum logic [1:0] {
      GRANT_NONE,
      GRANT_BUS,
      GRANT_VIDEO
   } grant_t;

endpackage

// File: rtl/ram_port_arbiter.sv
// Shares one RAM controller port between the chipset bus and the video
// fetcher, stretching bus cycles via memory_access_ready until served.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH    = 20,
   parameter int DATA_WIDTH    = 8,
   parameter int MAX_VIDEO_RUN = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] bus_address,
   input  logic [DATA_WIDTH-1:0] bus_data_in,
   input  logic                  bus_memory_read_n,
   input  logic                  bus_memory_write_n,
   input  logic                  bus_select_n,
   output logic [DATA_WIDTH-1:0] bus_data_out,
   output logic                  memory_access_ready,
   input  logic                  video_request,
   input  logic                  video_urgent,
   input  logic [ADDR_WIDTH-1:0] video_address,
   output logic                  video_acknowledge,
   output logic [DATA_WIDTH-1:0] video_data,
   output logic                  mem_request,
   output logic                  mem_write_enable,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data_out,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_data_in
);

   localparam logic [RUN_WIDTH-1:0] RUN_MAX = RUN_WIDTH'(MAX_VIDEO_RUN);

   state_t                 state;
   state_t                 state_next;
   grant_t                 grant;
   logic                   served;
   logic [RUN_WIDTH-1:0]   run;
   logic [RUN_WIDTH-1:0]   run_next;
   logic                   bus_active;
   logic                   want_bus;
   logic                   bus_write;

   assign bus_active = ~bus_select_n
                     & (~bus_memory_read_n | ~bus_memory_write_n);
   assign want_bus   = bus_active & ~served;
   assign bus_write  = ~bus_memory_write_n;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Urgent video may jump a waiting bus access at most RUN_MAX times.
   always_comb begin
      grant      = GRANT_NONE;
      run_next   = run;
      state_next = state;
      unique case (state)
         IDLE: begin
            if (want_bus && video_request && video_urgent
                && (run < RUN_MAX)) begin
               grant    = GRANT_VIDEO;
               run_next = run + RUN_WIDTH'(1);
            end else if (want_bus) begin
               grant    = GRANT_BUS;
               run_next = '0;
            end else if (video_request) begin
               grant    = GRANT_VIDEO;
            end
            unique case (grant)
               GRANT_BUS:   state_next = BUS_ACCESS;
               GRANT_VIDEO: state_next = VIDEO_ACCESS;
               default:     state_next = IDLE;
            endcase
         end
         BUS_ACCESS, VIDEO_ACCESS: begin
            if (mem_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_request         = (state != IDLE);
      memory_access_ready = ~want_bus;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         served            <= 1'b0;
         run               <= '0;
         mem_write_enable  <= 1'b0;
         mem_address       <= '0;
         mem_data_out      <= '0;
         bus_data_out      <= '0;
         video_acknowledge <= 1'b0;
         video_data        <= '0;
      end else begin
         run               <= run_next;
         video_acknowledge <= 1'b0;
         if (!bus_active) begin
            served <= 1'b0;
         end
         unique case (grant)
            GRANT_BUS: begin
               mem_address      <= bus_address;
               mem_write_enable <= bus_write;
               mem_data_out     <= bus_data_in;
            end
            GRANT_VIDEO: begin
               mem_address      <= video_address;
               mem_write_enable <= 1'b0;
            end
            default: ;
         endcase
         // An abandoned bus cycle still completes but is not reported.
         if (mem_ready) begin
            unique case (state)
               BUS_ACCESS: begin
                  if (bus_active) begin
                     served <= 1'b1;
                     if (!mem_write_enable) begin
                        bus_data_out <= mem_data_in;
                     end
                  end
               end
               VIDEO_ACCESS: begin
                  video_acknowledge <= 1'b1;
                  video_data        <= mem_data_in;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a RAM responder model, bus and
// video drivers, and a monitor checking returned data against a memory model.
module tb_ram_port_arbiter;

   localparam int AW = 20;
   localparam int DW = 8;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] bus_address;
   logic [DW-1:0] bus_data_in;
   logic          bus_memory_read_n;
   logic          bus_memory_write_n;
   logic          bus_select_n;
   logic [DW-1:0] bus_data_out;
   logic          memory_access_ready;
   logic          video_request;
   logic          video_urgent;
   logic [AW-1:0] video_address;
   logic          video_acknowledge;
   logic [DW-1:0] video_data;
   logic          mem_request;
   logic          mem_write_enable;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data_out;
   logic          mem_ready;
   logic [DW-1:0] mem_data_in;

   always #5 clock = ~clock;

   ram_port_arbiter #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .MAX_VIDEO_RUN(4)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus_address(bus_address),
      .bus_data_in(bus_data_in),
      .bus_memory_read_n(bus_memory_read_n),
      .bus_memory_write_n(bus_memory_write_n),
      .bus_select_n(bus_select_n),
      .bus_data_out(bus_data_out),
      .memory_access_ready(memory_access_ready),
      .video_request(video_request),
      .video_urgent(video_urgent),
      .video_address(video_address),
      .video_acknowledge(video_acknowledge),
      .video_data(video_data),
      .mem_request(mem_request),
      .mem_write_enable(mem_write_enable),
      .mem_address(mem_address),
      .mem_data_out(mem_data_out),
      .mem_ready(mem_ready),
      .mem_data_in(mem_data_in)
   );

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s timeout", name);
   endtask

   // Memory contents: ram is what the responder holds, model is what the
   // bench believes the bus has written.
   logic [DW-1:0] ram[int];
   logic [DW-1:0] model[int];

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      logic [DW-1:0] lo;
      lo = a[7:0];
      return (lo * 8'd7) ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h5A;
   endfunction

   function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
      return ram.exists(int'(a)) ? ram[int'(a)] : init_val(a);
   endfunction

   function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
      return model.exists(int'(a)) ? model[int'(a)] : init_val(a);
   endfunction

   logic [DW-1:0] bus_q[$];
   logic [DW-1:0] vid_q[$];
   int            log_q[$];
   int            ack_count = 0;
   int            forced_lat = -1;
   logic          last_we;
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_wdata;

   // RAM controller model: latches each new access and answers later.
   initial begin : responder
      logic          active;
      int            cnt;
      logic [AW-1:0] c_addr;
      logic          c_we;
      logic [DW-1:0] c_wd;
      active = 1'b0;
      cnt = 0;
      mem_ready = 1'b0;
      mem_data_in = '0;
      forever begin
         @(posedge clock);
         #1;
         mem_ready = 1'b0;
         if (!reset_n || !mem_request) begin
            active = 1'b0;
         end else begin
            if (!active) begin
               active = 1'b1;
               cnt = (forced_lat >= 0) ? forced_lat : $urandom_range(0, 3);
               c_addr = mem_address;
               c_we = mem_write_enable;
               c_wd = mem_data_out;
               last_addr = c_addr;
               last_we = c_we;
               last_wdata = c_wd;
               log_q.push_back(int'(c_addr));
            end else begin
               check("mem_hold", {mem_write_enable, mem_address},
                     {c_we, c_addr});
            end
            if (cnt == 0) begin
               mem_ready = 1'b1;
               if (c_we) begin
                  ram[int'(c_addr)] = c_wd;
               end else begin
                  mem_data_in = ram_rd(c_addr);
               end
               active = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   end

   initial begin : monitor
      logic seen;
      seen = 1'b0;
      forever begin
         @(negedge clock);
         if (video_acknowledge) begin
            ack_count++;
            if (vid_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL vid_unexpected actual=%0h required=none",
                        video_data);
            end else begin
               check("vid_data", video_data, vid_q.pop_front());
            end
         end
         if (reset_n && !bus_select_n
             && (!bus_memory_read_n || !bus_memory_write_n)) begin
            if (memory_access_ready && !seen) begin
               seen = 1'b1;
               if (bus_memory_write_n) begin
                  if (bus_q.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL bus_unexpected actual=%0h required=none",
                              bus_data_out);
                  end else begin
                     check("bus_data", bus_data_out, bus_q.pop_front());
                  end
               end
            end
         end else begin
            seen = 1'b0;
         end
      end
   end

   // Entered and left at #1 after a rising edge.
   task automatic bus_access(input logic [AW-1:0] a, input logic we,
                             input logic [DW-1:0] d, output int low);
      bus_address = a;
      bus_data_in = d;
      bus_select_n = 1'b0;
      if (we) begin
         bus_memory_write_n = 1'b0;
         model[int'(a)] = d;
      end else begin
         bus_memory_read_n = 1'b0;
         bus_q.push_back(model_rd(a));
      end
      #1;
      check("ready_low_at_start", memory_access_ready, 1'b0);
      low = 1;
      forever begin
         @(posedge clock);
         #1;
         if (memory_access_ready) break;
         low++;
         if (low > 200) begin
            timeout("bus_ready");
            break;
         end
      end
      @(posedge clock);
      #1;
      check("ready_hold", memory_access_ready, 1'b1);
      bus_select_n = 1'b1;
      bus_memory_read_n = 1'b1;
      bus_memory_write_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic video_run(input logic [AW-1:0] a, input int n,
                            input logic urg);
      int k;
      video_address = a;
      video_urgent = urg;
      for (int i = 0; i < n; i++) begin
         vid_q.push_back(init_val(a));
         video_request = 1'b1;
         k = 0;
         forever begin
            @(posedge clock);
            #1;
            if (video_acknowledge) break;
            k++;
            if (k > 200) begin
               timeout("video_ack");
               break;
            end
         end
      end
      video_request = 1'b0;
      video_urgent = 1'b0;
   endtask

   initial begin : stim
      int            low;
      int            idx;
      int            k;
      logic [DW-1:0] saved;
      bus_address = '0;
      bus_data_in = '0;
      bus_memory_read_n = 1'b1;
      bus_memory_write_n = 1'b1;
      bus_select_n = 1'b1;
      video_request = 1'b0;
      video_urgent = 1'b0;
      video_address = '0;
      #2;
      check("rst_ready", memory_access_ready, 1'b1);
      check("rst_req", mem_request, 1'b0);
      check("rst_ack", video_acknowledge, 1'b0);
      check("rst_bus_data", bus_data_out, '0);
      check("rst_vid_data", video_data, '0);
      check("rst_mem_addr", mem_address, '0);
      check("rst_mem_we", mem_write_enable, 1'b0);
      #10;
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Plain bus read with a three-cycle-late completion.
      ram[32'h12345] = 8'hA5;
      model[32'h12345] = 8'hA5;
      forced_lat = 2;
      bus_access(20'h12345, 1'b0, 8'h00, low);
      check("read_low_cycles", low, 4);
      check("read_addr", last_addr, 20'h12345);
      check("read_we", last_we, 1'b0);
      check("read_data", bus_data_out, 8'hA5);

      forced_lat = -1;
      bus_access(20'h00400, 1'b1, 8'h3C, low);
      check("write_we", last_we, 1'b1);
      check("write_data", last_wdata, 8'h3C);
      check("write_addr", last_addr, 20'h00400);
      check("write_keeps_bus_data", bus_data_out, 8'hA5);
      bus_access(20'h00400, 1'b0, 8'h00, low);

      // Bus and non-urgent video together: bus first.
      log_q.delete();
      ack_count = 0;
      fork
         bus_access(20'h00123, 1'b0, 8'h00, low);
         video_run(20'h80010, 1, 1'b0);
      join
      repeat (3) @(posedge clock);
      #1;
      check("both_count", log_q.size(), 2);
      if (log_q.size() == 2) begin
         check("both_first", log_q[0], 32'h00123);
         check("both_second", log_q[1], 32'h80010);
      end
      check("both_acks", ack_count, 1);

      // Urgent video preempts a waiting bus read at most four times.
      for (int r = 0; r < 2; r++) begin
         log_q.delete();
         fork
            bus_access(20'h00200, 1'b0, 8'h00, low);
            video_run(20'h80020, 6, 1'b1);
         join
         idx = -1;
         foreach (log_q[i]) begin
            if (log_q[i] == 32'h00200 && idx < 0) idx = i;
         end
         check("urgent_run", idx, 4);
      end

      // Bus strobe abandoned while its access is in flight.
      forced_lat = 4;
      saved = bus_data_out;
      bus_address = 20'h00300;
      bus_select_n = 1'b0;
      bus_memory_read_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      bus_select_n = 1'b1;
      bus_memory_read_n = 1'b1;
      k = 0;
      while (mem_request && k < 200) begin
         @(posedge clock);
         #1;
         k++;
      end
      if (k >= 200) timeout("abort_drain");
      @(posedge clock);
      #1;
      check("abort_bus_data", bus_data_out, saved);
      check("abort_ready", memory_access_ready, 1'b1);
      forced_lat = -1;
      bus_access(20'h00300, 1'b0, 8'h00, low);

      // Randomised mix of bus and video traffic.
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               logic [AW-1:0] a;
               logic          w;
               a = AW'($urandom_range(0, 31));
               w = 1'($urandom_range(0, 1));
               bus_access(a, w, DW'($urandom), low);
               repeat ($urandom_range(0, 3)) @(posedge clock);
               #1;
            end
         end
         begin
            for (int i = 0; i < 15; i++) begin
               video_run(20'h80000 | AW'($urandom_range(0, 255)),
                         $urandom_range(1, 3), 1'($urandom_range(0, 1)));
               repeat ($urandom_range(0, 4)) @(posedge clock);
               #1;
            end
         end
      join
      repeat (10) @(posedge clock);
      #1;
      check("bus_q_empty", bus_q.size(), 0);
      check("vid_q_empty", vid_q.size(), 0);

      // Reset arriving in the middle of a video access.
      forced_lat = 10;
      video_address = 20'h80050;
      video_request = 1'b1;
      k = 0;
      while (!mem_request && k < 200) begin
         @(posedge clock);
         #1;
         k++;
      end
      if (k >= 200) timeout("rst_video_grant");
      @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      check("midrst_req", mem_request, 1'b0);
      check("midrst_ready", memory_access_ready, 1'b1);
      check("midrst_ack", video_acknowledge, 1'b0);
      check("midrst_bus_data", bus_data_out, '0);
      check("midrst_vid_data", video_data, '0);
      video_request = 1'b0;
      vid_q.delete();
      repeat (2) @(posedge clock);
      #3;
      reset_n = 1'b1;
      forced_lat = -1;
      repeat (3) @(posedge clock);
      #1;
      check("postrst_idle", mem_request, 1'b0);
      check("postrst_ack", video_acknowledge, 1'b0);
      bus_access(20'h00011, 1'b0, 8'h00, low);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
